gen_counter_bank: RTL and testbench
===================================

// Module: gen_counter_bank
// PURPOSE
//  Parametrised bank of NCH independent counters, each elaborated through generate-if/for
//  in a named block ch[i]. Counter mode is chosen at elaboration by MODE; step is 2**STEP_LOG2.
//  Frontend test for parametrised generate, genvar loops, power constants and hierarchical
//  access to per-channel state. Sits beside the other gen_test* modules in the test suite.
// PARAMETERS
//  NCH        3  number of channels (>=1)
//  WIDTH      3  counter width per channel (1..16)
//  MODE       0  0=up-wrap, 1=up-saturate, 2=down-wrap; any other value = frozen (generate-else)
//  STEP_LOG2  0  step = 2**STEP_LOG2, truncated to WIDTH bits (0 when STEP_LOG2>=WIDTH)
//  INIT       4  reset/idle value per channel, truncated to WIDTH bits (default 2**2)
// PORTS
//  clk       in   1          single clock; all state updates on rising edge
//  rst       in   1          synchronous, active-high reset
//  en        in   NCH        per-channel count enable
//  load      in   NCH        per-channel load strobe
//  load_val  in   NCH*WIDTH  load data; channel i = [i*WIDTH +: WIDTH]
//  clr       in   NCH        per-channel clear of wrap_seen
//  count     out  NCH*WIDTH  registered counter values, same packing as load_val
//  tc        out  NCH        registered terminal-count flag per channel
//  wrap_seen out  NCH        sticky: tc has been asserted since reset/clr
//  all_tc    out  1          combinational &tc
//  any_tc    out  1          combinational |tc
// BEHAVIOUR
//  - Reset (rst=1 at edge): count[i]=INIT, tc=0, wrap_seen=0, regardless of en/load/clr.
//    Reset mid-count takes effect on that edge; no partial update.
//  - Priority per channel per edge: rst > load > en > hold.
//  - load: count<=load_val[i], tc<=0. load with en in the same cycle: load wins, no step.
//  - en, MODE 0: count<=(count+step) mod 2**WIDTH; tc<=1 iff the add carried out, else 0.
//  - en, MODE 1: count<=min(count+step, 2**WIDTH-1) computed at WIDTH+1 bits;
//    tc<=1 iff the new count == 2**WIDTH-1 (level, stays high while saturated and en=1).
//  - en, MODE 2: count<=(count-step) mod 2**WIDTH; tc<=1 iff the subtract borrowed.
//  - en=0 and load=0: count holds, tc<=0 (tc is a one-cycle flag aligned with the new count).
//  - step==0: count never moves under en; tc<=0 for MODE 0/2, MODE 1 rule unchanged.
//  - MODE outside 0..2: count fixed at INIT, tc=0, wrap_seen=0; load/en ignored.
//  - wrap_seen[i]: set on any edge where tc[i] becomes 1; cleared by clr[i];
//    set and clr in the same cycle -> set wins. Cleared by rst.
//  - Latency: one clock from en/load to count/tc; all_tc/any_tc follow tc combinationally.
//  - Channels are fully independent; no cross-channel interaction except all_tc/any_tc.
// STRUCTURE
//  - Package gen_counter_pkg: localparams MODE_UP_WRAP=0, MODE_UP_SAT=1, MODE_DN_WRAP=2;
//    function step_val(width, step_log2) returning the truncated 2**step_log2.
//  - Sub-module gen_counter_chan (one channel: count/tc/wrap_seen regs, mode generate-if),
//    instantiated in genvar loop block ch[i]; channel state visible as ch[i].u_chan.cnt_q.
//  - Top holds only the generate loop, port slicing and the all_tc/any_tc reduction.
// TESTING (defaults NCH=3, WIDTH=3, INIT=4, STEP_LOG2=0 unless stated)
//  1. rst=1 for 2 cycles with en=3'b111 -> count={4,4,4}, tc=0, wrap_seen=0, all_tc=0.
//  2. MODE=0, en[0]=1 for 4 cycles -> ch0 count 5,6,7,0; tc[0]=1 only with 0; wrap_seen[0]=1.
//  3. MODE=1, load ch1 with 6 then en 3 cycles -> 7,7,7; tc[1]=1 on all three; any_tc=1.
//  4. load[2]=1, en[2]=1, load_val=2 same cycle -> count ch2=2, tc[2]=0; clr+tc same cycle keeps wrap_seen=1.
//  5. MODE=2, STEP_LOG2=1, en all -> each 2,0,6; tc=3'b111 with 6, all_tc=1; then en=0 -> tc=0.
//  6. MODE=3 -> count stays 4 under load/en; rst asserted mid-count in MODE 0 -> next edge count=4, tc=0.

Source files
------------

// File: rtl/gen_counter_pkg.sv
// Shared mode encodings and step helper for the generate-built counter bank.
// Pure constants/functions: no latency, no flow control.
// Imported by the channel and the bank top.
package gen_counter_pkg;

    localparam int MODE_UP_WRAP = 0;
    localparam int MODE_UP_SAT  = 1;
    localparam int MODE_DN_WRAP = 2;

    // 2**step_log2 truncated to width bits; collapses to 0 once the bit falls off the top.
    function automatic int step_val(input int width, input int step_log2);
        if (step_log2 >= width || step_log2 < 0)
            return 0;
        return int'(1) << step_log2;
    endfunction

endpackage

// File: rtl/gen_counter_chan.sv
// One counter channel: count/tc/wrap_seen registers, behaviour picked at elaboration by MODE.
// Latency: one clock from en/load to cnt/tc/wrap_seen.
// No backpressure: en/load are sampled every edge.
module gen_counter_chan
    import gen_counter_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MODE      = MODE_UP_WRAP,
    parameter int STEP_LOG2 = 0,
    parameter int INIT      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap_seen
);

    localparam logic [WIDTH-1:0] STEP   = WIDTH'(step_val(WIDTH, STEP_LOG2));
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] MAX_V  = '1;

    logic [WIDTH-1:0] cnt_q;
    logic             tc_q;
    logic             ws_q;

    generate
        if (MODE == MODE_UP_WRAP || MODE == MODE_UP_SAT || MODE == MODE_DN_WRAP) begin : g_live
            logic [WIDTH-1:0] step_cnt;
            logic             step_tc;
            logic [WIDTH-1:0] cnt_d;
            logic             tc_d;
            logic             ws_d;

            if (MODE == MODE_UP_WRAP) begin : g_up_wrap
                logic [WIDTH:0] sum;
                assign sum      = {1'b0, cnt_q} + {1'b0, STEP};
                assign step_cnt = sum[WIDTH-1:0];
                assign step_tc  = sum[WIDTH];
            end else if (MODE == MODE_UP_SAT) begin : g_up_sat
                logic [WIDTH:0] sum;
                assign sum      = {1'b0, cnt_q} + {1'b0, STEP};
                assign step_cnt = sum[WIDTH] ? MAX_V : sum[WIDTH-1:0];
                // Level flag: stays high every enabled cycle spent at the ceiling.
                assign step_tc  = (step_cnt == MAX_V);
            end else begin : g_dn_wrap
                logic [WIDTH:0] diff;
                assign diff     = {1'b0, cnt_q} - {1'b0, STEP};
                assign step_cnt = diff[WIDTH-1:0];
                assign step_tc  = diff[WIDTH];
            end

            always_comb begin
                cnt_d = cnt_q;
                tc_d  = 1'b0;
                if (load) begin
                    cnt_d = load_val;
                end else if (en) begin
                    cnt_d = step_cnt;
                    tc_d  = step_tc;
                end
                // A fresh tc outranks a clear issued on the same edge.
                ws_d = tc_d | (ws_q & ~clr);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= INIT_V;
                    tc_q  <= 1'b0;
                    ws_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    tc_q  <= tc_d;
                    ws_q  <= ws_d;
                end
            end
        end else begin : g_frozen
            logic unused_ctrl;
            assign unused_ctrl = ^{en, load, load_val, clr};

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= INIT_V;
                    tc_q  <= 1'b0;
                    ws_q  <= 1'b0;
                end else begin
                    cnt_q <= INIT_V;
                    tc_q  <= 1'b0;
                    ws_q  <= 1'b0;
                end
            end
        end
    endgenerate

    assign cnt       = cnt_q;
    assign tc        = tc_q;
    assign wrap_seen = ws_q;

endmodule

// File: rtl/gen_counter_bank.sv
// Bank of NCH independent counters built in generate block ch[i], plus tc reductions.
// Latency: one clock to count/tc; all_tc/any_tc are combinational from tc.
// No backpressure: per-channel controls are sampled every edge.
module gen_counter_bank
    import gen_counter_pkg::*;
#(
    parameter int NCH       = 3,
    parameter int WIDTH     = 3,
    parameter int MODE      = MODE_UP_WRAP,
    parameter int STEP_LOG2 = 0,
    parameter int INIT      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*WIDTH-1:0] load_val,
    input  logic [NCH-1:0]       clr,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       tc,
    output logic [NCH-1:0]       wrap_seen,
    output logic                 all_tc,
    output logic                 any_tc
);

    for (genvar i = 0; i < NCH; i++) begin : ch
        gen_counter_chan #(
            .WIDTH     (WIDTH),
            .MODE      (MODE),
            .STEP_LOG2 (STEP_LOG2),
            .INIT      (INIT)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (en[i]),
            .load      (load[i]),
            .load_val  (load_val[i*WIDTH +: WIDTH]),
            .clr       (clr[i]),
            .cnt       (count[i*WIDTH +: WIDTH]),
            .tc        (tc[i]),
            .wrap_seen (wrap_seen[i])
        );
    end

    assign all_tc = &tc;
    assign any_tc = |tc;

endmodule

// File: tb/tb_gen_counter_bank.sv
// Four banks (up-wrap, up-sat, down-wrap step 2, frozen) driven by directed vectors;
// expectations are queued at issue and checked one cycle later by an independent monitor.
module tb_gen_counter_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a   [4];
    logic [2:0] en_a    [4];
    logic [2:0] load_a  [4];
    logic [8:0] lval_a  [4];
    logic [2:0] clr_a   [4];
    logic [8:0] cnt_o   [4];
    logic [2:0] tc_o    [4];
    logic [2:0] ws_o    [4];
    logic       all_o   [4];
    logic       any_o   [4];

    gen_counter_bank #(.NCH(3), .WIDTH(3), .MODE(0), .STEP_LOG2(0), .INIT(4)) d0 (
        .clk(clk), .rst(rst_a[0]), .en(en_a[0]), .load(load_a[0]), .load_val(lval_a[0]),
        .clr(clr_a[0]), .count(cnt_o[0]), .tc(tc_o[0]), .wrap_seen(ws_o[0]),
        .all_tc(all_o[0]), .any_tc(any_o[0]));

    gen_counter_bank #(.NCH(3), .WIDTH(3), .MODE(1), .STEP_LOG2(0), .INIT(4)) d1 (
        .clk(clk), .rst(rst_a[1]), .en(en_a[1]), .load(load_a[1]), .load_val(lval_a[1]),
        .clr(clr_a[1]), .count(cnt_o[1]), .tc(tc_o[1]), .wrap_seen(ws_o[1]),
        .all_tc(all_o[1]), .any_tc(any_o[1]));

    gen_counter_bank #(.NCH(3), .WIDTH(3), .MODE(2), .STEP_LOG2(1), .INIT(4)) d2 (
        .clk(clk), .rst(rst_a[2]), .en(en_a[2]), .load(load_a[2]), .load_val(lval_a[2]),
        .clr(clr_a[2]), .count(cnt_o[2]), .tc(tc_o[2]), .wrap_seen(ws_o[2]),
        .all_tc(all_o[2]), .any_tc(any_o[2]));

    gen_counter_bank #(.NCH(3), .WIDTH(3), .MODE(3), .STEP_LOG2(0), .INIT(4)) d3 (
        .clk(clk), .rst(rst_a[3]), .en(en_a[3]), .load(load_a[3]), .load_val(lval_a[3]),
        .clr(clr_a[3]), .count(cnt_o[3]), .tc(tc_o[3]), .wrap_seen(ws_o[3]),
        .all_tc(all_o[3]), .any_tc(any_o[3]));

    typedef struct {
        int         due;
        int         inst;
        logic [8:0] c;
        logic [2:0] t;
        logic [2:0] w;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic expect_next(input int k, input logic [8:0] ec, input logic [2:0] et,
                               input logic [2:0] ew, input string nm);
        exp_t e;
        e.due  = cyc + 1;
        e.inst = k;
        e.c    = ec;
        e.t    = et;
        e.w    = ew;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    task automatic idle_all();
        for (int j = 0; j < 4; j++) begin
            rst_a[j]  = 1'b0;
            en_a[j]   = 3'b000;
            load_a[j] = 3'b000;
            lval_a[j] = 9'o000;
            clr_a[j]  = 3'b000;
        end
    endtask

    // Drive one instance for one edge; every other bank idles.
    task automatic drive(input int k, input logic r, input logic [2:0] e, input logic [2:0] l,
                         input logic [8:0] v, input logic [2:0] c, input logic [8:0] ec,
                         input logic [2:0] et, input logic [2:0] ew, input string nm);
        @(negedge clk);
        idle_all();
        rst_a[k]  = r;
        en_a[k]   = e;
        load_a[k] = l;
        lval_a[k] = v;
        clr_a[k]  = c;
        expect_next(k, ec, et, ew, nm);
    endtask

    // Monitor: pops every expectation due on this edge and compares all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check({e.nm, ".due"},   e.due,            cyc);
                check({e.nm, ".count"}, cnt_o[e.inst],    e.c);
                check({e.nm, ".tc"},    tc_o[e.inst],     e.t);
                check({e.nm, ".wrap"},  ws_o[e.inst],     e.w);
                check({e.nm, ".all"},   all_o[e.inst],    &e.t);
                check({e.nm, ".any"},   any_o[e.inst],    |e.t);
                if (e.inst == 0)
                    check({e.nm, ".ch0_state"}, d0.ch[0].u_chan.cnt_q, e.c[2:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        idle_all();

        // Reset with every enable high: all banks park at INIT.
        for (int cy = 0; cy < 2; cy++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                rst_a[k] = 1'b1;
                en_a[k]  = 3'b111;
                expect_next(k, 9'o444, 3'b000, 3'b000, $sformatf("reset%0d_b%0d", cy, k));
            end
        end

        // Up-wrap: ch0 counts 5,6,7,0 and flags the carry.
        drive(0, 0, 3'b001, 3'b000, 9'o000, 3'b000, 9'o445, 3'b000, 3'b000, "upw_5");
        drive(0, 0, 3'b001, 3'b000, 9'o000, 3'b000, 9'o446, 3'b000, 3'b000, "upw_6");
        drive(0, 0, 3'b001, 3'b000, 9'o000, 3'b000, 9'o447, 3'b000, 3'b000, "upw_7");
        drive(0, 0, 3'b001, 3'b000, 9'o000, 3'b000, 9'o440, 3'b001, 3'b001, "upw_0");
        drive(0, 0, 3'b000, 3'b000, 9'o000, 3'b000, 9'o440, 3'b000, 3'b001, "upw_hold");
        drive(0, 0, 3'b000, 3'b000, 9'o000, 3'b001, 9'o440, 3'b000, 3'b000, "upw_clr");
        drive(0, 0, 3'b000, 3'b001, 9'o007, 3'b000, 9'o447, 3'b000, 3'b000, "upw_load7");
        drive(0, 0, 3'b001, 3'b000, 9'o000, 3'b001, 9'o440, 3'b001, 3'b001, "upw_clr_vs_tc");
        drive(0, 0, 3'b100, 3'b100, 9'o200, 3'b000, 9'o240, 3'b000, 3'b001, "upw_load_wins");
        drive(0, 0, 3'b111, 3'b000, 9'o000, 3'b000, 9'o351, 3'b000, 3'b001, "upw_all_en");
        drive(0, 1, 3'b111, 3'b111, 9'o777, 3'b000, 9'o444, 3'b000, 3'b000, "upw_mid_rst");
        drive(0, 0, 3'b000, 3'b000, 9'o000, 3'b000, 9'o444, 3'b000, 3'b000, "upw_post_rst");

        // Up-saturate: ch1 loaded to 6, then pinned at 7 with tc held high.
        drive(1, 0, 3'b000, 3'b010, 9'o060, 3'b000, 9'o464, 3'b000, 3'b000, "sat_load6");
        drive(1, 0, 3'b010, 3'b000, 9'o000, 3'b000, 9'o474, 3'b010, 3'b010, "sat_7a");
        drive(1, 0, 3'b010, 3'b000, 9'o000, 3'b000, 9'o474, 3'b010, 3'b010, "sat_7b");
        drive(1, 0, 3'b010, 3'b000, 9'o000, 3'b000, 9'o474, 3'b010, 3'b010, "sat_7c");
        drive(1, 0, 3'b111, 3'b000, 9'o000, 3'b000, 9'o575, 3'b010, 3'b010, "sat_all_en");
        drive(1, 0, 3'b000, 3'b000, 9'o000, 3'b000, 9'o575, 3'b000, 3'b010, "sat_hold");

        // Down-wrap by 2: 4 -> 2 -> 0 -> 6 with every channel borrowing together.
        drive(2, 0, 3'b111, 3'b000, 9'o000, 3'b000, 9'o222, 3'b000, 3'b000, "dn_2");
        drive(2, 0, 3'b111, 3'b000, 9'o000, 3'b000, 9'o000, 3'b000, 3'b000, "dn_0");
        drive(2, 0, 3'b111, 3'b000, 9'o000, 3'b000, 9'o666, 3'b111, 3'b111, "dn_6");
        drive(2, 0, 3'b000, 3'b000, 9'o000, 3'b000, 9'o666, 3'b000, 3'b111, "dn_hold");
        drive(2, 0, 3'b010, 3'b000, 9'o000, 3'b111, 9'o646, 3'b000, 3'b000, "dn_clr_step");

        // Frozen mode ignores load and enable.
        drive(3, 0, 3'b111, 3'b111, 9'o123, 3'b000, 9'o444, 3'b000, 3'b000, "frz_load_en");
        drive(3, 0, 3'b111, 3'b000, 9'o000, 3'b000, 9'o444, 3'b000, 3'b000, "frz_en");

        @(negedge clk);
        idle_all();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
